// File: rtl/merge_rx_pkg.sv
// Shared types and defaults for the merge receive stage.
//   rx_state_t  : handshake FSM encoding (IDLE = 0, ACK_HI = 1)
//   rx_entry_t  : one buffered token {src, data} at the default data width
//   *_DEF       : default parameter values for merge_rx_fifo
package merge_rx_pkg;

    localparam int DATA_W_DEF      = 8;
    localparam int DEPTH_DEF       = 4;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        ACK_HI = 1'b1
    } rx_state_t;

    // Bit layout of a FIFO entry; the top stores entries as {src, data}
    // so this ordering also holds when DATA_W differs from the default.
    typedef struct packed {
        logic                  src;
        logic [DATA_W_DEF-1:0] data;
    } rx_entry_t;

endpackage

// File: rtl/sync_ff.sv
// Reset-to-0 flop chain used to bring an asynchronous level into CLK.
// Ports:
//   CLK, MR_n : clock and asynchronous active-low reset
//   d         : asynchronous input level
//   q         : d delayed by STAGES clock edges
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic CLK,
    input  logic MR_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge CLK or negedge MR_n) begin
        if (!MR_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/merge_rx_fifo.sv
// Clocked receive stage behind the two-input self-timed merge.
// Synchronises the 4-phase Send request, returns Ack, and buffers each
// token with its source tag in a first-word-fall-through FIFO.
// Ports:
//   CLK, MR_n            : clock, asynchronous active-low master reset
//   Send_in, Ack_out     : 4-phase handshake with the merge
//   Data_in, Src_in      : bundled token data and A-else-B source flag
//   Dout, Dout_src       : head entry (reads 0 when empty)
//   Dout_valid/ready     : consumer handshake; pop when both high
//   Count, Full          : registered occupancy and Count == DEPTH
//
// state  | meaning
// IDLE   | Ack low; capture when synchronised Send is high and FIFO not full
// ACK_HI | Ack high; wait for synchronised Send to return low
module merge_rx_fifo
    import merge_rx_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int DEPTH       = DEPTH_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                       CLK,
    input  logic                       MR_n,
    input  logic                       Send_in,
    input  logic [DATA_W-1:0]          Data_in,
    input  logic                       Src_in,
    output logic                       Ack_out,
    output logic [DATA_W-1:0]          Dout,
    output logic                       Dout_src,
    output logic                       Dout_valid,
    input  logic                       Dout_ready,
    output logic [$clog2(DEPTH+1)-1:0] Count,
    output logic                       Full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    rx_state_t          state, state_next;
    logic               send_s;
    logic               push, pop;
    logic [PTR_W-1:0]   wptr, rptr;
    logic [CNT_W-1:0]   count_q, count_next;
    logic               full_q;
    logic [DATA_W:0]    mem [DEPTH];

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync_send (
        .CLK  (CLK),
        .MR_n (MR_n),
        .d    (Send_in),
        .q    (send_s)
    );

    always_ff @(posedge CLK or negedge MR_n) begin
        if (!MR_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Full comes from the registered count, so a blocked request waits at
    // least one edge after a pop before it is captured.
    always_comb begin
        state_next = state;
        push       = 1'b0;
        case (state)
            IDLE: begin
                if (send_s && !full_q) begin
                    push       = 1'b1;
                    state_next = ACK_HI;
                end
            end
            ACK_HI: begin
                if (!send_s) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign Ack_out = (state == ACK_HI);
    assign pop     = Dout_valid && Dout_ready;

    always_comb begin
        count_next = count_q;
        case ({push, pop})
            2'b10:   count_next = count_q + CNT_W'(1);
            2'b01:   count_next = count_q - CNT_W'(1);
            default: count_next = count_q;
        endcase
    end

    always_ff @(posedge CLK or negedge MR_n) begin
        if (!MR_n) begin
            wptr    <= '0;
            rptr    <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (pop) begin
                rptr <= rptr + PTR_W'(1);
            end
            count_q <= count_next;
            full_q  <= (count_next == CNT_W'(DEPTH));
        end
    end

    // Storage is not reset; Data_in/Src_in are stable here by bundling.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wptr] <= {Src_in, Data_in};
        end
    end

    assign Dout_valid = (count_q != '0);
    assign Dout       = Dout_valid ? mem[rptr][DATA_W-1:0] : '0;
    assign Dout_src   = Dout_valid ? mem[rptr][DATA_W]     : 1'b0;
    assign Count      = count_q;
    assign Full       = full_q;

endmodule

// File: tb/tb_merge_rx_fifo.sv
module tb_merge_rx_fifo;

    logic       CLK = 1'b0;
    logic       MR_n;
    logic       Send_in;
    logic [7:0] Data_in;
    logic       Src_in;
    logic       Ack_out;
    logic [7:0] Dout;
    logic       Dout_src;
    logic       Dout_valid;
    logic       Dout_ready;
    logic [2:0] Count;
    logic       Full;

    int n_cmp = 0;
    int n_bad = 0;

    merge_rx_fifo #(.DATA_W(8), .DEPTH(4), .SYNC_STAGES(2)) dut (
        .CLK        (CLK),
        .MR_n       (MR_n),
        .Send_in    (Send_in),
        .Data_in    (Data_in),
        .Src_in     (Src_in),
        .Ack_out    (Ack_out),
        .Dout       (Dout),
        .Dout_src   (Dout_src),
        .Dout_valid (Dout_valid),
        .Dout_ready (Dout_ready),
        .Count      (Count),
        .Full       (Full)
    );

    initial forever #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_ack(input logic level, input int budget, input string tag);
        int k = 0;
        while (Ack_out !== level && k < budget) begin
            tick();
            k++;
        end
        if (Ack_out !== level) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: Ack_out timeout got %b want %b", tag, Ack_out, level);
        end
    endtask

    task automatic send_token(input logic [7:0] d, input logic s, input string tag);
        Data_in = d; Src_in = s; Send_in = 1'b1;
        wait_ack(1'b1, 10, tag);
        Send_in = 1'b0;
        wait_ack(1'b0, 10, tag);
    endtask

    task automatic test_reset();
        MR_n = 1'b0; Send_in = 1'b1; Data_in = 8'h3C; Src_in = 1'b0; Dout_ready = 1'b0;
        repeat (2) tick();
        n_cmp++; if (Ack_out !== 1'b0) begin n_bad++; $display("FAIL rst_ack got %b want 0", Ack_out); end
        n_cmp++; if (Count !== 3'd0) begin n_bad++; $display("FAIL rst_count got %0d want 0", Count); end
        n_cmp++; if (Dout_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", Dout_valid); end
        n_cmp++; if (Dout !== 8'h00 || Full !== 1'b0) begin n_bad++; $display("FAIL rst_dout got %h/%b want 00/0", Dout, Full); end
        MR_n = 1'b1;
        tick(); tick();
        n_cmp++; if (Ack_out !== 1'b0) begin n_bad++; $display("FAIL rst_rel_edge2 got %b want 0", Ack_out); end
        tick();
        n_cmp++; if (Ack_out !== 1'b1) begin n_bad++; $display("FAIL rst_rel_edge3 got %b want 1", Ack_out); end
        n_cmp++; if (Count !== 3'd1) begin n_bad++; $display("FAIL rst_rel_count got %0d want 1", Count); end
        n_cmp++; if (Dout !== 8'h3C || Dout_src !== 1'b0) begin n_bad++; $display("FAIL rst_rel_dout got %h/%b want 3c/0", Dout, Dout_src); end
        Send_in = 1'b0;
        wait_ack(1'b0, 8, "rst_fall");
        Dout_ready = 1'b1; tick(); Dout_ready = 1'b0;
        n_cmp++; if (Count !== 3'd0 || Dout_valid !== 1'b0) begin n_bad++; $display("FAIL rst_drain got %0d/%b want 0/0", Count, Dout_valid); end
    endtask

    task automatic test_single();
        Data_in = 8'hA5; Src_in = 1'b1; Send_in = 1'b1;
        tick(); tick();
        n_cmp++; if (Ack_out !== 1'b0) begin n_bad++; $display("FAIL single_early got %b want 0", Ack_out); end
        tick();
        n_cmp++; if (Ack_out !== 1'b1) begin n_bad++; $display("FAIL single_ack got %b want 1", Ack_out); end
        n_cmp++; if (Dout !== 8'hA5 || Dout_src !== 1'b1 || Dout_valid !== 1'b1) begin
            n_bad++; $display("FAIL single_head got %h/%b/%b want a5/1/1", Dout, Dout_src, Dout_valid); end
        Send_in = 1'b0;
        tick(); tick();
        n_cmp++; if (Ack_out !== 1'b1) begin n_bad++; $display("FAIL single_hold got %b want 1", Ack_out); end
        tick();
        n_cmp++; if (Ack_out !== 1'b0) begin n_bad++; $display("FAIL single_fall got %b want 0", Ack_out); end
        Dout_ready = 1'b1; tick(); Dout_ready = 1'b0;
        n_cmp++; if (Count !== 3'd0) begin n_bad++; $display("FAIL single_pop got %0d want 0", Count); end
    endtask

    task automatic test_full();
        logic [7:0] exp_d;
        logic       stuck;
        for (int i = 1; i <= 4; i++) send_token(8'(i), 1'b0, "full_fill");
        n_cmp++; if (Count !== 3'd4 || Full !== 1'b1) begin n_bad++; $display("FAIL full_level got %0d/%b want 4/1", Count, Full); end
        Data_in = 8'h05; Src_in = 1'b1; Send_in = 1'b1;
        stuck = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (Ack_out !== 1'b0) stuck = 1'b1;
        end
        n_cmp++; if (stuck !== 1'b0) begin n_bad++; $display("FAIL full_block ack seen 1 want 0"); end
        n_cmp++; if (Dout !== 8'h01) begin n_bad++; $display("FAIL full_head got %h want 01", Dout); end
        Dout_ready = 1'b1; tick(); Dout_ready = 1'b0;
        n_cmp++; if (Ack_out !== 1'b0 || Count !== 3'd3 || Dout !== 8'h02) begin
            n_bad++; $display("FAIL full_pop got ack %b cnt %0d dout %h want 0/3/02", Ack_out, Count, Dout); end
        tick();
        n_cmp++; if (Ack_out !== 1'b1 || Count !== 3'd4) begin
            n_bad++; $display("FAIL full_retry got ack %b cnt %0d want 1/4", Ack_out, Count); end
        Send_in = 1'b0;
        wait_ack(1'b0, 8, "full_fall");
        for (int i = 2; i <= 5; i++) begin
            exp_d = 8'(i);
            n_cmp++; if (Dout !== exp_d || Dout_src !== (i == 5)) begin
                n_bad++; $display("FAIL full_drain got %h/%b want %h/%b", Dout, Dout_src, exp_d, (i == 5)); end
            Dout_ready = 1'b1; tick(); Dout_ready = 1'b0;
        end
        n_cmp++; if (Count !== 3'd0) begin n_bad++; $display("FAIL full_empty got %0d want 0", Count); end
    endtask

    task automatic test_push_pop();
        send_token(8'h20, 1'b1, "pp_a");
        send_token(8'h21, 1'b0, "pp_b");
        n_cmp++; if (Count !== 3'd2) begin n_bad++; $display("FAIL pp_pre got %0d want 2", Count); end
        Data_in = 8'h22; Src_in = 1'b1; Send_in = 1'b1;
        tick(); tick();
        Dout_ready = 1'b1; tick(); Dout_ready = 1'b0;
        n_cmp++; if (Ack_out !== 1'b1 || Count !== 3'd2) begin
            n_bad++; $display("FAIL pp_same_edge got ack %b cnt %0d want 1/2", Ack_out, Count); end
        n_cmp++; if (Dout !== 8'h21 || Dout_src !== 1'b0) begin n_bad++; $display("FAIL pp_head got %h/%b want 21/0", Dout, Dout_src); end
        Send_in = 1'b0;
        wait_ack(1'b0, 8, "pp_fall");
        Dout_ready = 1'b1; tick(); Dout_ready = 1'b0;
        n_cmp++; if (Dout !== 8'h22 || Dout_src !== 1'b1) begin n_bad++; $display("FAIL pp_next got %h/%b want 22/1", Dout, Dout_src); end
        Dout_ready = 1'b1; tick(); Dout_ready = 1'b0;
        n_cmp++; if (Count !== 3'd0) begin n_bad++; $display("FAIL pp_empty got %0d want 0", Count); end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_d;
        logic       exp_s;
        Dout_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            exp_d = 8'(i);
            exp_s = (i % 2 == 0);
            Data_in = exp_d; Src_in = exp_s; Send_in = 1'b1;
            wait_ack(1'b1, 10, "wrap_ack");
            n_cmp++; if (Dout !== exp_d || Dout_src !== exp_s || Dout_valid !== 1'b1) begin
                n_bad++; $display("FAIL wrap_tok%0d got %h/%b/%b want %h/%b/1", i, Dout, Dout_src, Dout_valid, exp_d, exp_s); end
            Send_in = 1'b0;
            wait_ack(1'b0, 10, "wrap_fall");
        end
        n_cmp++; if (Count !== 3'd0 || Dout_valid !== 1'b0) begin
            n_bad++; $display("FAIL wrap_end got %0d/%b want 0/0", Count, Dout_valid); end
        Dout_ready = 1'b0;
    endtask

    task automatic test_reset_ack_hi();
        send_token(8'h55, 1'b0, "rah_pre");
        Data_in = 8'h77; Src_in = 1'b1; Send_in = 1'b1;
        wait_ack(1'b1, 10, "rah_ack");
        n_cmp++; if (Count !== 3'd2) begin n_bad++; $display("FAIL rah_count_pre got %0d want 2", Count); end
        #2;
        MR_n = 1'b0; Send_in = 1'b0;
        #1;
        n_cmp++; if (Ack_out !== 1'b0 || Count !== 3'd0 || Dout_valid !== 1'b0) begin
            n_bad++; $display("FAIL rah_async got ack %b cnt %0d v %b want 0/0/0", Ack_out, Count, Dout_valid); end
        tick();
        MR_n = 1'b1;
        repeat (4) tick();
        n_cmp++; if (Ack_out !== 1'b0 || Count !== 3'd0) begin
            n_bad++; $display("FAIL rah_idle got ack %b cnt %0d want 0/0", Ack_out, Count); end
        Data_in = 8'h88; Src_in = 1'b0; Send_in = 1'b1;
        tick(); tick(); tick();
        n_cmp++; if (Ack_out !== 1'b1 || Count !== 3'd1 || Dout !== 8'h88 || Dout_src !== 1'b0) begin
            n_bad++; $display("FAIL rah_next got ack %b cnt %0d dout %h/%b want 1/1/88/0", Ack_out, Count, Dout, Dout_src); end
        Send_in = 1'b0;
        wait_ack(1'b0, 8, "rah_fall");
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_push_pop();
        test_wrap();
        test_reset_ack_hi();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
